ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-CPU shared-RAM arbiter that sits between the per-core cache pairs (icache/dcache of CPU0 and CPU1) and the single-port RAM model. It serialises the four request streams onto one RAM port, with data before instruction inside a core and round-robin between cores. It holds the RAM command stable across BUSY cycles and returns a one-cycle wait release to the winning requester.

## Interface
Parameters:
- CPUS, 2, number of cores; only 2 is supported.
- AW, 32, address/word width (word_t).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- iREN  in  2  instruction read request, one bit per CPU.
- iaddr  in  2x32  instruction address per CPU.
- dREN  in  2  data read request per CPU.
- dWEN  in  2  data write request per CPU.
- daddr  in  2x32  data address per CPU.
- dstore  in  2x32  write data per CPU.
- iwait  out  2  per CPU; 0 for the cycle instruction data is valid.
- dwait  out  2  per CPU; 0 for the cycle the data access completes.
- iload  out  2x32  per CPU; equals ramload.
- dload  out  2x32  per CPU; equals ramload.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

## Operation
- Registered state: fsm {IDLE, BUSY}, gcpu (1 bit, granted CPU), gdata (1 = data port, 0 = instruction port), last (1 bit, last CPU served).
- IDLE behaviour:
  - Compute pending per CPU: dREN|dWEN|iREN.
  - If both CPUs are pending, pick CPU != last. Otherwise pick the single pending CPU.
  - Within the chosen CPU, data wins over instruction (gdata = dREN|dWEN).
  - If any request is pending, register the grant and go to BUSY. Otherwise stay in IDLE.
- BUSY behaviour:
  - Drive ramaddr from daddr[gcpu] or iaddr[gcpu].
  - Drive ramstore = dstore[gcpu].
  - ramWEN = gdata & dWEN[gcpu].
  - ramREN = gdata ? (dREN[gcpu] & ~dWEN[gcpu]) : iREN[gcpu].
  - dREN and dWEN both high is treated as a write.
- Completion: when ramstate==ACCESS in BUSY, the granted wait bit is driven 0 in that same cycle, combinationally. On that edge: last <= gcpu, fsm <= IDLE.
- Withdrawal: if the granted request signal(s) drop while in BUSY, drop ramREN/ramWEN immediately. Go to IDLE without updating last; no wait is released.
- ERROR or FREE/BUSY ramstate in BUSY: hold the command and stay in BUSY; retry indefinitely.
- Outputs in IDLE: ramREN=ramWEN=0, ramaddr=0, ramstore=0.
- Wait bits: all non-granted wait bits are 1 at all times.
- Load outputs: iload/dload always mirror ramload.
- Coherence and snooping are out of scope.

## Timing
- Reset (RST high at an edge): fsm=IDLE, gcpu=0, gdata=0, last=1, so CPU0 wins the first tie. All waits 1, ramREN=ramWEN=0, ramaddr=ramstore=0.
- Reset mid-BUSY aborts the access with no wait release; RAM strobes are 0 in the cycle after the reset edge.
- Latency: a request first seen in cycle n reaches the RAM port in cycle n+1. Earliest wait release is cycle n+1 if ramstate==ACCESS then.
- Handshake: the requester holds its request until its wait is 0. The arbiter returns to IDLE at that edge and re-arbitrates in the following cycle. Each access costs at least 2 cycles (one IDLE, one or more BUSY).
- A new request arriving while in BUSY is not considered until the next IDLE cycle.
- Back-to-back contention: CPUs strictly alternate. Each CPU waits at most one other access.

## Test plan
- Single access: after reset, CPU0 iREN=1, iaddr=0x100, RAM ACCESS on the first BUSY cycle -> ramREN=1, ramaddr=0x100 in cycle 1; iwait[0]=0 in cycle 1 with iload[0]=ramload; IDLE in cycle 2.
- Tie and alternation: both CPUs hold dREN with daddr 0x200/0x300, RAM ACCESS after 2 BUSY cycles -> serviced in order CPU0, CPU1, CPU0, CPU1; each dwait low exactly one cycle.
- Data over instruction: CPU1 iREN and dWEN both high, daddr=0x40, dstore=0xDEADBEEF -> the write goes first (ramWEN=1, ramstore=0xDEADBEEF); the instruction fetch follows in the next grant.
- ERROR hold: ramstate=ERROR for 3 cycles, then ACCESS -> ramaddr and strobes stable for all 4 BUSY cycles; a single wait pulse on the ACCESS cycle.
- Withdrawal and reset: CPU0 drops dREN in the second BUSY cycle -> strobes 0 in that cycle, IDLE next, last unchanged. Separately, RST asserted in BUSY -> all outputs at reset values the next cycle, and CPU0 wins the next tie.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between the icache/dcache pairs of
// two CPU cores. Requests are granted while IDLE; the grant is held over one
// or more BUSY cycles until the RAM reports ACCESS or the requester withdraws.
// Inside a core the data port beats the instruction port. When both cores
// are pending, the core that was not served last wins.
//
// Ports:
//   CLK, RST         clock, synchronous active-high reset
//   iREN/iaddr       per-CPU instruction read request and address
//   dREN/dWEN/daddr  per-CPU data read/write request and address
//   dstore           per-CPU write data
//   iwait/dwait      per-CPU wait bits; 0 only in the cycle the access completes
//   iload/dload      per-CPU load data (mirrors ramload)
//   ramREN/ramWEN    RAM strobes
//   ramaddr/ramstore RAM address and write data
//   ramload          RAM read data
//   ramstate         FREE=0, BUSY=1, ACCESS=2, ERROR=3
//
// state | meaning
// IDLE  | no grant held; arbitrate among pending requests
// BUSY  | grant held; RAM command driven until ACCESS or withdrawal
module ram_arbiter #(
  parameter int CPUS = 2,  // only 2 is supported
  parameter int AW   = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS-1:0][AW-1:0]  iaddr,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS-1:0][AW-1:0]  daddr,
  input  logic [CPUS-1:0][AW-1:0]  dstore,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS-1:0][AW-1:0]  iload,
  output logic [CPUS-1:0][AW-1:0]  dload,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [AW-1:0]            ramaddr,
  output logic [AW-1:0]            ramstore,
  input  logic [AW-1:0]            ramload,
  input  logic [1:0]               ramstate
);

  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  state_t state_q, state_d;
  logic   gcpu_q, gcpu_d;
  logic   gdata_q, gdata_d;
  logic   last_q, last_d;

  logic [CPUS-1:0] pend;
  logic            pick;
  logic            live;
  logic            done;

  assign pend = dREN | dWEN | iREN;

  // With a single pending core, pend[1] names it; on a tie the core that
  // was not served last wins.
  always_comb begin
    pick = pend[1];
    if (&pend) pick = ~last_q;
  end

  // The granted request is still being asserted by its owner.
  assign live = gdata_q ? (dREN[gcpu_q] | dWEN[gcpu_q]) : iREN[gcpu_q];
  assign done = (state_q == BUSY) && live && (ramstate == RAM_ACCESS);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      gcpu_q  <= 1'b0;
      gdata_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gcpu_q  <= gcpu_d;
      gdata_q <= gdata_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gcpu_d  = gcpu_q;
    gdata_d = gdata_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (|pend) begin
          gcpu_d  = pick;
          gdata_d = dREN[pick] | dWEN[pick];
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Withdrawal returns to IDLE without touching the fairness pointer.
        if (!live) begin
          state_d = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          last_d  = gcpu_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = '1;
    dwait    = '1;
    if (state_q == BUSY) begin
      ramaddr  = gdata_q ? daddr[gcpu_q] : iaddr[gcpu_q];
      ramstore = dstore[gcpu_q];
      // dREN together with dWEN is a write.
      ramWEN   = gdata_q & dWEN[gcpu_q];
      ramREN   = gdata_q ? (dREN[gcpu_q] & ~dWEN[gcpu_q]) : iREN[gcpu_q];
      if (done) begin
        if (gdata_q) dwait[gcpu_q] = 1'b0;
        else         iwait[gcpu_q] = 1'b0;
      end
    end
  end

  assign iload = {CPUS{ramload}};
  assign dload = {CPUS{ramload}};

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed scenarios with literal expectations,
// then randomized requesters that follow the wait handshake. A transaction
// level model (current grant, last served core) predicts every output in
// every cycle.
module tb_ram_arbiter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic             RST;
  logic [1:0]       iREN, dREN, dWEN;
  logic [1:0][31:0] iaddr, daddr, dstore;
  logic [1:0]       iwait, dwait;
  logic [1:0][31:0] iload, dload;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;

  ram_arbiter #(.CPUS(2), .AW(32)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model: an outstanding grant (owner core, data or instruction port) and
  // the core that completed most recently.
  bit m_active = 0;
  int m_cpu = 0;
  bit m_data = 0;
  int m_last = 1;

  logic [1:0] prev_iw = 2'b11, prev_dw = 2'b11;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_live();
    if (m_data) return (dREN[m_cpu] | dWEN[m_cpu]);
    return iREN[m_cpu];
  endfunction

  task automatic compare();
    logic [1:0]  e_iw = 2'b11;
    logic [1:0]  e_dw = 2'b11;
    logic        e_ren = 1'b0;
    logic        e_wen = 1'b0;
    logic [31:0] e_addr = 32'h0;
    logic [31:0] e_store = 32'h0;
    if (m_active) begin
      e_addr  = m_data ? daddr[m_cpu] : iaddr[m_cpu];
      e_store = dstore[m_cpu];
      if (m_data) begin
        e_wen = dWEN[m_cpu];
        e_ren = dREN[m_cpu] && !dWEN[m_cpu];
      end else begin
        e_ren = iREN[m_cpu];
      end
      if (m_live() && ramstate == 2'd2) begin
        if (m_data) e_dw[m_cpu] = 1'b0;
        else        e_iw[m_cpu] = 1'b0;
      end
    end
    chk("ramREN",   32'(ramREN),   32'(e_ren));
    chk("ramWEN",   32'(ramWEN),   32'(e_wen));
    chk("ramaddr",  ramaddr,       e_addr);
    chk("ramstore", ramstore,      e_store);
    chk("iwait",    32'(iwait),    32'(e_iw));
    chk("dwait",    32'(dwait),    32'(e_dw));
    for (int c = 0; c < 2; c++) begin
      chk("iload", iload[c], ramload);
      chk("dload", dload[c], ramload);
    end
  endtask

  task automatic model_update();
    bit p0, p1;
    p0 = iREN[0] | dREN[0] | dWEN[0];
    p1 = iREN[1] | dREN[1] | dWEN[1];
    if (RST) begin
      m_active = 0;
      m_last   = 1;
    end else if (!m_active) begin
      if (p0 || p1) begin
        m_cpu    = (p0 && p1) ? 1 - m_last : (p1 ? 1 : 0);
        m_data   = dREN[m_cpu] | dWEN[m_cpu];
        m_active = 1;
      end
    end else if (!m_live()) begin
      m_active = 0;
    end else if (ramstate == 2'd2) begin
      m_last   = m_cpu;
      m_active = 0;
    end
  endtask

  task automatic settle();
    #3;
    compare();
    prev_iw = iwait;
    prev_dw = dwait;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic clear();
    iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramstate = 2'd0;
  endtask

  task automatic do_reset();
    clear();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  logic [31:0] t2_addr [4] = '{32'h200, 32'h300, 32'h200, 32'h300};
  logic [1:0]  t2_dw   [4] = '{2'b10, 2'b01, 2'b10, 2'b01};

  bit ireq [2];
  bit dreq [2];

  initial begin
    clear();
    ramload = 32'h0;
    RST = 1'b1;
    tick();
    RST = 1'b0;

    // Reset values and single instruction fetch.
    settle();
    chk("rst_ren", 32'(ramREN), 32'h0);
    chk("rst_iwait", 32'(iwait), 32'h3);
    chk("rst_dwait", 32'(dwait), 32'h3);
    chk("rst_addr", ramaddr, 32'h0);
    tick();
    iREN[0] = 1'b1; iaddr[0] = 32'h100; ramstate = 2'd2; ramload = 32'hCAFE0001;
    settle();
    chk("t1_idle_ren", 32'(ramREN), 32'h0);
    tick();
    settle();
    chk("t1_ren", 32'(ramREN), 32'h1);
    chk("t1_addr", ramaddr, 32'h100);
    chk("t1_iwait", 32'(iwait), 32'h2);
    chk("t1_iload", iload[0], 32'hCAFE0001);
    tick();
    iREN[0] = 1'b0;
    settle();
    chk("t1_back_idle", 32'(ramREN), 32'h0);
    tick();

    // Tie and strict alternation.
    do_reset();
    dREN = 2'b11; daddr[0] = 32'h200; daddr[1] = 32'h300;
    for (int k = 0; k < 4; k++) begin
      ramstate = 2'd0; settle();
      chk("t2_idle", 32'(ramREN), 32'h0);
      tick();
      ramstate = 2'd1; settle();
      chk("t2_addr", ramaddr, t2_addr[k]);
      chk("t2_hold_dwait", 32'(dwait), 32'h3);
      tick();
      ramstate = 2'd2; settle();
      chk("t2_dwait", 32'(dwait), 32'(t2_dw[k]));
      tick();
    end
    clear(); settle(); tick();

    // Data over instruction on CPU1.
    do_reset();
    iREN[1] = 1'b1; iaddr[1] = 32'h80;
    dWEN[1] = 1'b1; daddr[1] = 32'h40; dstore[1] = 32'hDEADBEEF;
    ramstate = 2'd2;
    settle(); tick();
    settle();
    chk("t3_wen", 32'(ramWEN), 32'h1);
    chk("t3_ren", 32'(ramREN), 32'h0);
    chk("t3_store", ramstore, 32'hDEADBEEF);
    chk("t3_addr", ramaddr, 32'h40);
    chk("t3_dwait", 32'(dwait), 32'h1);
    tick();
    dWEN[1] = 1'b0;
    settle(); tick();
    settle();
    chk("t3_iren", 32'(ramREN), 32'h1);
    chk("t3_iaddr", ramaddr, 32'h80);
    chk("t3_iwait", 32'(iwait), 32'h1);
    tick();
    clear(); settle(); tick();

    // ERROR hold then ACCESS.
    do_reset();
    dREN[0] = 1'b1; daddr[0] = 32'h55;
    settle(); tick();
    for (int i = 0; i < 3; i++) begin
      ramstate = 2'd3; settle();
      chk("t4_hold_addr", ramaddr, 32'h55);
      chk("t4_hold_ren", 32'(ramREN), 32'h1);
      chk("t4_hold_dwait", 32'(dwait), 32'h3);
      tick();
    end
    ramstate = 2'd2; settle();
    chk("t4_addr", ramaddr, 32'h55);
    chk("t4_dwait", 32'(dwait), 32'h2);
    tick();
    dREN[0] = 1'b0; ramstate = 2'd0; settle();
    chk("t4_after", 32'(dwait), 32'h3);
    tick();

    // Withdrawal keeps the fairness pointer (CPU0 was served last).
    dREN[0] = 1'b1; daddr[0] = 32'h66;
    settle(); tick();
    ramstate = 2'd1; settle();
    chk("t5_ren", 32'(ramREN), 32'h1);
    tick();
    dREN[0] = 1'b0; settle();
    chk("t5_drop_ren", 32'(ramREN), 32'h0);
    chk("t5_drop_dwait", 32'(dwait), 32'h3);
    tick();
    dREN = 2'b11; daddr[1] = 32'h77; settle();
    chk("t5_idle", 32'(ramREN), 32'h0);
    tick();
    ramstate = 2'd2; settle();
    chk("t5_cpu1_wins", ramaddr, 32'h77);
    chk("t5_cpu1_dwait", 32'(dwait), 32'h1);
    tick();
    // Serve CPU0 so a reset is the only way it can win the next tie.
    dREN = 2'b01; ramstate = 2'd0; settle(); tick();
    ramstate = 2'd2; settle();
    chk("t5_cpu0_dwait", 32'(dwait), 32'h2);
    tick();
    dREN = 2'b10; ramstate = 2'd0; settle(); tick();
    ramstate = 2'd1; RST = 1'b1; settle();
    chk("t5_pre_rst_addr", ramaddr, 32'h77);
    tick();
    RST = 1'b0; dREN = 2'b11; settle();
    chk("t5_rst_ren", 32'(ramREN), 32'h0);
    chk("t5_rst_addr", ramaddr, 32'h0);
    chk("t5_rst_dwait", 32'(dwait), 32'h3);
    tick();
    ramstate = 2'd2; settle();
    chk("t5_rst_tie", ramaddr, 32'h66);
    chk("t5_rst_tie_dwait", 32'(dwait), 32'h2);
    tick();
    clear(); settle(); tick();

    // Randomized requesters honouring the wait handshake.
    for (int c = 0; c < 2; c++) begin ireq[c] = 0; dreq[c] = 0; end
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (ireq[c]) begin
          if (!prev_iw[c] || $urandom_range(0, 39) == 0) ireq[c] = 0;
        end else if ($urandom_range(0, 2) == 0) begin
          ireq[c] = 1; iaddr[c] = $urandom;
        end
        iREN[c] = ireq[c];
        if (dreq[c]) begin
          if (!prev_dw[c] || $urandom_range(0, 39) == 0) begin
            dreq[c] = 0; dREN[c] = 1'b0; dWEN[c] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          int kind;
          kind = $urandom_range(0, 7);
          dreq[c] = 1;
          dREN[c] = (kind < 4 || kind == 7);
          dWEN[c] = (kind >= 4);
          daddr[c] = $urandom; dstore[c] = $urandom;
        end
      end
      ramstate = $urandom_range(0, 1) ? 2'd2 : 2'($urandom_range(0, 3));
      ramload = $urandom;
      RST = ($urandom_range(0, 299) == 0);
      settle();
      tick();
    end
    RST = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
